// File: rtl/matriz_param.sv
// Frame buffer of LARGURA x ALTURA pixels with bounds-checked single-port access
// and a full-frame clear sweep that owns the memory while it runs.
module matriz_param #(
  parameter int                    LARGURA       = 320,
  parameter int                    ALTURA        = 240,
  parameter int                    BITS_PIXEL    = 8,
  parameter logic [BITS_PIXEL-1:0] VALOR_LIMPEZA = '0,
  localparam int WL = (ALTURA > 1) ? $clog2(ALTURA) : 1,
  localparam int WC = (LARGURA > 1) ? $clog2(LARGURA) : 1,
  localparam int WA = (LARGURA * ALTURA > 1) ? $clog2(LARGURA * ALTURA) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WL-1:0]         linha,
  input  logic [WC-1:0]         coluna,
  input  logic                  escrever,
  input  logic [BITS_PIXEL-1:0] byte_entrada,
  input  logic                  ler,
  input  logic                  limpar,
  output logic [BITS_PIXEL-1:0] byte_saida,
  output logic                  saida_valida,
  output logic                  fora_limite,
  output logic                  ocupado,
  output logic                  pronto
);

  localparam int N  = LARGURA * ALTURA;
  localparam int WP = WL + WC + 1;
  localparam logic [WP-1:0] N_W    = WP'(N);
  localparam logic [WA-1:0] ULTIMO = WA'(N - 1);
  localparam logic [WL:0]   ALT_W  = (WL + 1)'(ALTURA);
  localparam logic [WC:0]   LARG_W = (WC + 1)'(LARGURA);

  typedef enum logic [0:0] {OCIOSO = 1'b0, LIMPANDO = 1'b1} estado_t;

  estado_t                 estado_q, estado_d;
  logic [WA-1:0]           contador_q, contador_d;
  logic [BITS_PIXEL-1:0]   byte_saida_q;
  logic                    saida_valida_q, saida_valida_d;
  logic                    fora_limite_q, fora_limite_d;
  logic                    ocupado_q, ocupado_d;
  logic                    pronto_q, pronto_d;
  logic [BITS_PIXEL-1:0]   mem_q [0:N-1];

  logic [WP-1:0]           endereco_largo_s;
  logic [WA-1:0]           endereco_s;
  logic                    em_faixa_s;
  logic                    ocioso_s;
  logic                    le_s;
  logic                    grava_s;
  logic [WA-1:0]           end_grava_s;
  logic [BITS_PIXEL-1:0]   dado_grava_s;

  // Address computed wide enough that an out-of-range line cannot alias a valid word.
  always_comb begin
    endereco_largo_s = WP'(linha) * WP'(LARGURA) + WP'(coluna);
    endereco_s       = endereco_largo_s[WA-1:0];
    em_faixa_s       = ({1'b0, linha} < ALT_W) && ({1'b0, coluna} < LARG_W)
                       && (endereco_largo_s < N_W);
    ocioso_s         = (estado_q == OCIOSO);
    le_s             = ocioso_s && ler && !escrever;
    if (ocioso_s) begin
      grava_s      = escrever && em_faixa_s;
      end_grava_s  = endereco_s;
      dado_grava_s = byte_entrada;
    end else begin
      grava_s      = 1'b1;
      end_grava_s  = contador_q;
      dado_grava_s = VALOR_LIMPEZA;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    case (estado_q)
      OCIOSO: begin
        if (limpar) begin
          estado_d   = LIMPANDO;
          contador_d = '0;
        end else begin
          estado_d   = OCIOSO;
        end
      end
      LIMPANDO: begin
        if (contador_q == ULTIMO) begin
          estado_d   = OCIOSO;
        end else begin
          contador_d = contador_q + WA'(1);
        end
      end
      default: begin
        estado_d   = OCIOSO;
        contador_d = '0;
      end
    endcase
    ocupado_d      = (estado_d == LIMPANDO);
    pronto_d       = (estado_d == LIMPANDO) && (contador_d == ULTIMO);
    saida_valida_d = le_s;
    fora_limite_d  = ocioso_s && (escrever || ler) && !em_faixa_s;
  end

  // RAM write port; reset blocks the write but never clears contents.
  always_ff @(posedge clock) begin
    if (!reset && grava_s) begin
      mem_q[end_grava_s] <= dado_grava_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      contador_q     <= '0;
      byte_saida_q   <= '0;
      saida_valida_q <= 1'b0;
      fora_limite_q  <= 1'b0;
      ocupado_q      <= 1'b0;
      pronto_q       <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      contador_q     <= contador_d;
      saida_valida_q <= saida_valida_d;
      fora_limite_q  <= fora_limite_d;
      ocupado_q      <= ocupado_d;
      pronto_q       <= pronto_d;
      if (le_s) begin
        byte_saida_q <= em_faixa_s ? mem_q[endereco_s] : '0;
      end
    end
  end

  assign byte_saida   = byte_saida_q;
  assign saida_valida = saida_valida_q;
  assign fora_limite  = fora_limite_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;

endmodule
